// File: rtl/aurora_rx_lane_core.sv
// aurora_rx_lane_core
//   Receive back-end for one Aurora 64b/66b lane: reassembles 66-bit blocks
//   from a serial bit stream, acquires and keeps block lock by bit-slipping,
//   and (optionally) descrambles the 64-bit payload.
//
// Build option:
//   AURORA_RX_DESCRAMBLE_EN  defined   -> x^58+x^39+1 self-synchronous descrambler
//                            undefined -> rx_data_o carries the raw payload bits
//
// Ports:
//   clk_rx_i       sole clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   rx_data_i      serial data bit
//   rx_bit_vld_i   rx_data_i is valid this cycle
//   rx_polarity_i  1 = invert rx_data_i before processing
//   rx_data_o      payload of the last accepted block
//   rx_header_o    sync header of the last accepted block
//   rx_valid_o     one-cycle pulse per accepted block
//   rx_stat_o      [0] block_lock, [1] last header invalid, [7:2] slip count (sat. 63)
module aurora_rx_lane_core #(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned ERR_WINDOW = 64,
    parameter int unsigned ERR_MAX    = 16
) (
    input  logic        clk_rx_i,
    input  logic        rst_n_i,
    input  logic        rx_data_i,
    input  logic        rx_bit_vld_i,
    input  logic        rx_polarity_i,
    output logic [63:0] rx_data_o,
    output logic [1:0]  rx_header_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_stat_o
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int unsigned EW = $clog2(ERR_MAX + 1);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } state_t;

    state_t        state_q,    state_d;
    logic [64:0]   sh_q,       sh_d;
    logic [6:0]    bit_cnt_q,  bit_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [BW-1:0] blk_cnt_q,  blk_cnt_d;
    logic [EW-1:0] err_cnt_q,  err_cnt_d;
    logic          slip_q,     slip_d;
    logic [5:0]    slip_cnt_q, slip_cnt_d;
    logic          hdr_inv_q,  hdr_inv_d;
    logic [63:0]   data_q,     data_d;
    logic [1:0]    header_q,   header_d;
    logic          valid_q,    valid_d;
`ifdef AURORA_RX_DESCRAMBLE_EN
    logic [57:0]   scr_q,      scr_d;
`endif

    logic       in_bit;
    logic       out_bit;
    logic [1:0] hdr;
    logic       hdr_ok;

    // The shifter stores header bits raw and payload bits already descrambled,
    // so together with the incoming bit it forms the finished 66-bit block.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        good_cnt_d = good_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        err_cnt_d  = err_cnt_q;
        slip_d     = slip_q;
        slip_cnt_d = slip_cnt_q;
        hdr_inv_d  = hdr_inv_q;
        data_d     = data_q;
        header_d   = header_q;
        valid_d    = 1'b0;
`ifdef AURORA_RX_DESCRAMBLE_EN
        scr_d      = scr_q;
`endif
        in_bit  = rx_data_i ^ rx_polarity_i;
        out_bit = in_bit;
        hdr     = sh_q[64:63];
        hdr_ok  = hdr[1] ^ hdr[0];

        if (rx_bit_vld_i) begin
            if (slip_q) begin
                // Discarded bit: shifter, bit counter and history all hold.
                slip_d = 1'b0;
            end else begin
`ifdef AURORA_RX_DESCRAMBLE_EN
                if (bit_cnt_q >= 7'd2) begin
                    out_bit = in_bit ^ scr_q[38] ^ scr_q[57];
                    scr_d   = {scr_q[56:0], in_bit};
                end
`endif
                sh_d = {sh_q[63:0], out_bit};
                if (bit_cnt_q == 7'd65) begin
                    bit_cnt_d = '0;
                    hdr_inv_d = ~hdr_ok;
                    if (hdr_ok && (state_q == ST_LOCKED)) begin
                        valid_d  = 1'b1;
                        data_d   = {sh_q[62:0], out_bit};
                        header_d = hdr;
                    end
                    case (state_q)
                        ST_UNLOCKED: begin
                            if (hdr_ok) begin
                                good_cnt_d = good_cnt_q + 1'b1;
                                if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
                                    state_d   = ST_LOCKED;
                                    blk_cnt_d = '0;
                                    err_cnt_d = '0;
                                end
                            end else begin
                                good_cnt_d = '0;
                                slip_d     = 1'b1;
                                if (slip_cnt_q != 6'd63) begin
                                    slip_cnt_d = slip_cnt_q + 1'b1;
                                end
                            end
                        end
                        default: begin
                            if (!hdr_ok && (err_cnt_q == EW'(ERR_MAX - 1))) begin
                                state_d    = ST_UNLOCKED;
                                good_cnt_d = '0;
                                slip_d     = 1'b1;
                            end else if (blk_cnt_q == BW'(ERR_WINDOW - 1)) begin
                                blk_cnt_d = '0;
                                err_cnt_d = '0;
                            end else begin
                                blk_cnt_d = blk_cnt_q + 1'b1;
                                err_cnt_d = err_cnt_q + EW'(~hdr_ok);
                            end
                        end
                    endcase
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_UNLOCKED;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            good_cnt_q <= '0;
            blk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            slip_q     <= 1'b0;
            slip_cnt_q <= '0;
            hdr_inv_q  <= 1'b0;
            data_q     <= '0;
            header_q   <= '0;
            valid_q    <= 1'b0;
`ifdef AURORA_RX_DESCRAMBLE_EN
            scr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            good_cnt_q <= good_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            slip_q     <= slip_d;
            slip_cnt_q <= slip_cnt_d;
            hdr_inv_q  <= hdr_inv_d;
            data_q     <= data_d;
            header_q   <= header_d;
            valid_q    <= valid_d;
`ifdef AURORA_RX_DESCRAMBLE_EN
            scr_q      <= scr_d;
`endif
        end
    end

    assign rx_data_o   = data_q;
    assign rx_header_o = header_q;
    assign rx_valid_o  = valid_q;
    assign rx_stat_o   = {slip_cnt_q, hdr_inv_q, (state_q == ST_LOCKED)};

endmodule

// File: tb/tb_aurora_rx_lane_core.sv
// Testbench for aurora_rx_lane_core: random headers/payloads are serialised
// (scrambled when AURORA_RX_DESCRAMBLE_EN is defined) and the received block
// stream is compared with the transmitted one.
module tb_aurora_rx_lane_core;

    localparam int unsigned NMAX = 320;

    logic        clk_rx_i;
    logic        rst_n_i;
    logic        rx_data_i;
    logic        rx_bit_vld_i;
    logic        rx_polarity_i;
    logic [63:0] rx_data_o;
    logic [1:0]  rx_header_o;
    logic        rx_valid_o;
    logic [7:0]  rx_stat_o;

    aurora_rx_lane_core dut (
        .clk_rx_i      (clk_rx_i),
        .rst_n_i       (rst_n_i),
        .rx_data_i     (rx_data_i),
        .rx_bit_vld_i  (rx_bit_vld_i),
        .rx_polarity_i (rx_polarity_i),
        .rx_data_o     (rx_data_o),
        .rx_header_o   (rx_header_o),
        .rx_valid_o    (rx_valid_o),
        .rx_stat_o     (rx_stat_o)
    );

    initial clk_rx_i = 1'b0;
    always #5 clk_rx_i = ~clk_rx_i;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned p0      = 0;

    logic [1:0]  hdr_a [NMAX];
    logic [31:0] r_a   [NMAX];
    logic [57:0] scr_s;

    int unsigned ev_cyc[$];
    logic [63:0] ev_data[$];
    logic [1:0]  ev_hdr[$];
    logic [7:0]  ev_stat[$];
    int unsigned lk_cyc[$];
    logic        lk_val[$];
    logic        lk_prev = 1'b0;

    always @(posedge clk_rx_i) cyc <= cyc + 1;

    always @(negedge clk_rx_i) begin
        if (rst_n_i) begin
            if (rx_valid_o) begin
                ev_cyc.push_back(cyc);
                ev_data.push_back(rx_data_o);
                ev_hdr.push_back(rx_header_o);
                ev_stat.push_back(rx_stat_o);
            end
            if (rx_stat_o[0] != lk_prev) begin
                lk_cyc.push_back(cyc);
                lk_val.push_back(rx_stat_o[0]);
                lk_prev = rx_stat_o[0];
            end
        end else begin
            lk_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Payload word of block n; the block index is recoverable from the word.
    function automatic logic [63:0] gen_word(input int unsigned n);
`ifdef AURORA_RX_DESCRAMBLE_EN
        return {n, n};
`else
        return {r_a[n], r_a[n] ^ n};
`endif
    endfunction

    function automatic int unsigned idx_of(input logic [63:0] d);
`ifdef AURORA_RX_DESCRAMBLE_EN
        return d[31:0];
`else
        return d[31:0] ^ d[63:32];
`endif
    endfunction

    task automatic drive_bit(input logic b, input int unsigned g, input logic pol);
        for (int unsigned i = 0; i < g; i++) begin
            rx_bit_vld_i = 1'b0;
            rx_data_i    = 1'($urandom_range(0, 1));
            @(negedge clk_rx_i);
        end
        rx_bit_vld_i = 1'b1;
        rx_data_i    = b ^ pol;
        @(negedge clk_rx_i);
    endtask

    task automatic send_block(input int unsigned n, input int unsigned g, input logic pol,
                              input int drop_pos);
        logic [65:0] blk;
        logic [63:0] w;
        logic        c;
        w = gen_word(n);
        blk[65:64] = hdr_a[n];
        for (int i = 63; i >= 0; i--) begin
`ifdef AURORA_RX_DESCRAMBLE_EN
            c     = w[i] ^ scr_s[38] ^ scr_s[57];
            scr_s = {scr_s[56:0], c};
`else
            c = w[i];
`endif
            blk[i] = c;
        end
        for (int i = 65; i >= 0; i--) begin
            if (i != drop_pos) drive_bit(blk[i], g, pol);
        end
    endtask

    task automatic run(input int unsigned k, input int unsigned nblk, input int unsigned g,
                       input logic pol, input int drop_blk, input int drop_pos);
        ev_cyc.delete(); ev_data.delete(); ev_hdr.delete(); ev_stat.delete();
        lk_cyc.delete(); lk_val.delete();
        scr_s = '0;
        rx_polarity_i = pol;
        p0 = cyc;
        for (int unsigned i = 0; i < k; i++) drive_bit(1'($urandom_range(0, 1)), g, pol);
        for (int unsigned n = 0; n < nblk; n++)
            send_block(n, g, pol, (int'(n) == drop_blk) ? drop_pos : -1);
        rx_bit_vld_i = 1'b0;
        repeat (4) @(negedge clk_rx_i);
    endtask

    task automatic do_reset();
        rst_n_i      = 1'b0;
        rx_bit_vld_i = 1'b0;
        repeat (10) @(negedge clk_rx_i);
        check("rst_data",   rx_data_o,   64'd0);
        check("rst_header", rx_header_o, 64'd0);
        check("rst_valid",  rx_valid_o,  64'd0);
        check("rst_stat",   rx_stat_o,   64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_rx_i);
    endtask

    task automatic check_aligned(input int unsigned g, input int unsigned nblk);
        int unsigned per;
        per = (g + 1) * 66;
        check("al_lock_events", lk_val.size(), 1);
        if (lk_val.size() >= 1) begin
            check("al_lock_val",  lk_val[0], 1);
            check("al_lock_time", lk_cyc[0] - p0, per * 32);
        end
        check("al_valid_count", ev_cyc.size(), nblk - 32);
        foreach (ev_cyc[i]) begin
            check("al_time", ev_cyc[i] - p0, per * (33 + i));
            check("al_data", ev_data[i], gen_word(32 + i));
            check("al_hdr",  ev_hdr[i],  hdr_a[32 + i]);
            check("al_stat", ev_stat[i], 8'h01);
        end
    endtask

    task automatic check_mis(input int unsigned k, input int unsigned nblk);
        int unsigned idx;
        int unsigned prev;
        int unsigned exp_slip;
        exp_slip = (k > 63) ? 63 : k;
        prev = 0;
        check("mis_slips",  rx_stat_o[7:2], exp_slip);
        check("mis_locked", rx_stat_o[0], 1);
        check("mis_any_valid", ev_cyc.size() > 0, 1);
        foreach (ev_cyc[i]) begin
            idx = idx_of(ev_data[i]);
            if (i > 0) check("mis_consec", idx, prev + 1);
            if (idx < nblk) begin
                check("mis_data", ev_data[i], gen_word(idx));
                check("mis_hdr",  ev_hdr[i],  hdr_a[idx]);
            end else begin
                check("mis_idx_range", idx, nblk - 1);
            end
            check("mis_stat", ev_stat[i], {6'(exp_slip), 2'b01});
            prev = idx;
        end
    endtask

    task automatic check_drop(input int unsigned nblk, input int unsigned dblk);
        int unsigned npre;
        int unsigned idx;
        int unsigned prev;
        logic        seen;
        npre = 0;
        prev = 0;
        seen = 1'b0;
        check("drop_lock_events", lk_val.size(), 3);
        if (lk_val.size() == 3) begin
            check("drop_lock0", lk_val[0], 1);
            check("drop_lock1", lk_val[1], 0);
            check("drop_lock2", lk_val[2], 1);
            check("drop_lock_time", lk_cyc[0] - p0, 66 * 32);
            check("drop_loss_late", (lk_cyc[1] - p0) > 66 * (dblk + 1), 1);
            foreach (ev_cyc[i]) begin
                if (ev_cyc[i] - p0 <= 66 * dblk) begin
                    check("drop_pre_data", ev_data[i], gen_word(32 + npre));
                    npre++;
                end else if (ev_cyc[i] > lk_cyc[2]) begin
                    idx = idx_of(ev_data[i]);
                    if (seen) check("drop_post_consec", idx, prev + 1);
                    else      check("drop_gap_pos", idx > dblk, 1);
                    if (idx < nblk) begin
                        check("drop_post_data", ev_data[i], gen_word(idx));
                        check("drop_post_hdr",  ev_hdr[i],  hdr_a[idx]);
                    end else begin
                        check("drop_idx_range", idx, nblk - 1);
                    end
                    prev = idx;
                    seen = 1'b1;
                end
            end
            check("drop_pre_count", npre, dblk - 32);
            check("drop_post_seen", seen, 1);
            check("drop_last_idx",  prev, nblk - 1);
        end
        check("drop_slips",    rx_stat_o[7:2], 63);
        check("drop_relocked", rx_stat_o[0], 1);
    endtask

    initial begin
        int unsigned kv[3];
        rst_n_i       = 1'b0;
        rx_data_i     = 1'b0;
        rx_bit_vld_i  = 1'b0;
        rx_polarity_i = 1'b0;
        for (int unsigned n = 0; n < NMAX; n++) begin
            hdr_a[n] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            r_a[n]   = $urandom;
        end
        @(negedge clk_rx_i);
        do_reset();

        run(0, 40, 0, 1'b0, -1, -1);
        check_aligned(0, 40);

        kv[0] = 1;
        kv[1] = $urandom_range(2, 40);
        kv[2] = 65;
        foreach (kv[i]) begin
            do_reset();
            run(kv[i], 3 * kv[i] + 60, 0, 1'b0, -1, -1);
            check_mis(kv[i], 3 * kv[i] + 60);
        end

        do_reset();
        run(0, 300, 0, 1'b0, 40, 30);
        check_drop(300, 40);

        // Partial block in flight when reset hits.
        for (int unsigned i = 0; i < 30; i++) drive_bit(1'($urandom_range(0, 1)), 0, 1'b0);
        do_reset();
        run(0, 40, 0, 1'b1, -1, -1);
        check_aligned(0, 40);

        do_reset();
        run(0, 40, 1, 1'b0, -1, -1);
        check_aligned(1, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
